// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Instruction-cache miss handler. Accepts a line-miss request, fetches the
// 64-byte line as a 16-beat AXI4 INCR read burst, assembles the beats into a
// 512-bit line and writes tag/data/valid into the ICache RAM in one cycle.
// Also provides a whole-cache invalidate sweep.
//
// Ports
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   miss_req/miss_addr  : refill request from the lookup stage
//   miss_ready          : high only when idle; request taken on req & ready
//   refill_done/_err    : one-cycle completion pulse, error flag with it
//   flush_req/flush_done: invalidate-all request and completion pulse
//   ar*/r*              : AXI4 read address / read data channels (master)
//   ram_wen/a/d/dina/w_valid : ICache tag/data/valid RAM write port
//
// Every output is decoded from registered state, so no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
  parameter int INDEX_SIZE    = 6,
  parameter int WORD_OFF_SIZE = 4,
  parameter int TAG_SIZE      = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          miss_req,
  input  logic [31:0]                   miss_addr,
  output logic                          miss_ready,
  output logic                          refill_done,
  output logic                          refill_err,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [31:0]                   araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [31:0]                   rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready,
  output logic                          ram_wen,
  output logic [INDEX_SIZE-1:0]         ram_a,
  output logic [TAG_SIZE-1:0]           ram_d,
  output logic [(32<<WORD_OFF_SIZE)-1:0] ram_dina,
  output logic                          ram_w_valid
);

  localparam int LINE_W = 32 << WORD_OFF_SIZE;
  localparam int BEATS  = 1 << WORD_OFF_SIZE;
  localparam int OFF_W  = WORD_OFF_SIZE + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AR    = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;

  logic [2:0]               state;
  logic [TAG_SIZE-1:0]      tag;
  logic [INDEX_SIZE-1:0]    index;
  logic [WORD_OFF_SIZE-1:0] beat_cnt;
  logic [INDEX_SIZE-1:0]    flush_cnt;
  logic                     err;
  logic [LINE_W-1:0]        line;

  // Byte/word offset bits of the miss address are irrelevant: the burst is
  // always line-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tag       <= '0;
      index     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      err       <= 1'b0;
      line      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Flush wins over a simultaneous miss; the miss is held by the
          // requester and taken once the sweep finishes.
          if (flush_req) begin
            state     <= S_FLUSH;
            flush_cnt <= '0;
          end else if (miss_req) begin
            state    <= S_AR;
            tag      <= miss_addr[31 -: TAG_SIZE];
            index    <= miss_addr[OFF_W +: INDEX_SIZE];
            beat_cnt <= '0;
            err      <= 1'b0;
            // Cleared so that words missing after an early rlast read as 0.
            line     <= '0;
          end
        end
        S_AR: begin
          if (arready) state <= S_RECV;
        end
        S_RECV: begin
          if (rvalid) begin
            line[{beat_cnt, 5'd0} +: 32] <= rdata;
            beat_cnt <= beat_cnt + 1'b1;
            // A short burst (rlast before the final beat) poisons the line.
            if ((rresp != 2'b00) || (rlast && !(&beat_cnt))) err <= 1'b1;
            // The beat count, not rlast, defines the end of a full burst.
            if ((&beat_cnt) || rlast) state <= S_WRITE;
          end
        end
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        S_FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (&flush_cnt) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fixed burst shape: 16 beats of 4 bytes, incrementing.
  assign arlen   = 8'(BEATS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Address is held in registers for the whole AR phase, so it is stable
  // while arready is low.
  assign araddr  = {tag, index, {OFF_W{1'b0}}};

  assign miss_ready  = (state == S_IDLE);
  assign arvalid     = (state == S_AR);
  assign rready      = (state == S_RECV);
  assign refill_done = (state == S_DONE);
  assign refill_err  = (state == S_DONE) && err;
  assign flush_done  = (state == S_FLUSH) && (&flush_cnt);

  // RAM port: refill write carries the line, flush writes clear everything.
  assign ram_wen     = (state == S_WRITE) || (state == S_FLUSH);
  assign ram_a       = (state == S_FLUSH) ? flush_cnt : index;
  assign ram_d       = (state == S_WRITE) ? tag  : '0;
  assign ram_dina    = (state == S_WRITE) ? line : '0;
  assign ram_w_valid = (state == S_WRITE) && !err;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         refill_done;
  logic         refill_err;
  logic         flush_req;
  logic         flush_done;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic         ram_wen;
  logic [5:0]   ram_a;
  logic [19:0]  ram_d;
  logic [511:0] ram_dina;
  logic         ram_w_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.INDEX_SIZE(6), .WORD_OFF_SIZE(4), .TAG_SIZE(20)) dut (
    .clk(clk), .reset(reset),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .refill_done(refill_done), .refill_err(refill_err),
    .flush_req(flush_req), .flush_done(flush_done),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .ram_wen(ram_wen), .ram_a(ram_a), .ram_d(ram_d), .ram_dina(ram_dina),
    .ram_w_valid(ram_w_valid)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete miss transaction with a behavioural AXI slave.
  // gap_mode: 0 = rvalid every cycle, 1 = rvalid every other cycle, 2 = random.
  task automatic run_miss(input logic [31:0] addr, input int ar_delay, input int gap_mode,
                          input int err_beat, input int rlast_beat, input bit rand_data,
                          input string name);
    logic [31:0]  words [16];
    logic [511:0] exp_line;
    bit           exp_err;
    bit           in_recv;
    bit           give;
    bit           finished;
    int           n_beats;
    int           sent;
    int           write_exp;
    int           recv_start;

    n_beats  = rlast_beat + 1;
    exp_line = '0;
    exp_err  = (rlast_beat != 15);
    for (int k = 0; k < 16; k++) words[k] = rand_data ? $urandom : 32'(k);
    for (int k = 0; k < n_beats; k++) begin
      exp_line[k*32 +: 32] = words[k];
      if (k == err_beat) exp_err = 1'b1;
    end

    chk({name, ":miss_ready_before"}, 512'(miss_ready), 512'(1'b1));
    miss_req  = 1'b1;
    miss_addr = addr;
    step();
    miss_req  = 1'b0;
    miss_addr = $urandom;

    sent       = 0;
    write_exp  = -1;
    recv_start = 2 + ar_delay;
    finished   = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      chk({name, ":arvalid"}, 512'(arvalid), 512'(cyc <= 1 + ar_delay));
      if (cyc <= 1 + ar_delay) begin
        chk({name, ":araddr"},  512'(araddr),  512'(addr & 32'hFFFF_FFC0));
        chk({name, ":arlen"},   512'(arlen),   512'(8'd15));
        chk({name, ":arsize"},  512'(arsize),  512'(3'd2));
        chk({name, ":arburst"}, 512'(arburst), 512'(2'd1));
      end
      in_recv = (cyc >= recv_start) && (sent < n_beats);
      chk({name, ":rready"}, 512'(rready), 512'(in_recv));
      chk({name, ":ram_wen"}, 512'(ram_wen), 512'(cyc == write_exp));
      if (cyc == write_exp) begin
        chk({name, ":ram_a"},       512'(ram_a),       512'(addr[11:6]));
        chk({name, ":ram_d"},       512'(ram_d),       512'(addr[31:12]));
        chk({name, ":ram_dina"},    ram_dina,          exp_line);
        chk({name, ":ram_w_valid"}, 512'(ram_w_valid), 512'(!exp_err));
      end
      chk({name, ":refill_done"}, 512'(refill_done), 512'(write_exp > 0 && cyc == write_exp + 1));
      if (write_exp > 0 && cyc == write_exp + 1)
        chk({name, ":refill_err"}, 512'(refill_err), 512'(exp_err));
      chk({name, ":miss_ready"}, 512'(miss_ready), 512'(write_exp > 0 && cyc >= write_exp + 2));
      if (write_exp > 0 && cyc == write_exp + 2) begin
        finished = 1'b1;
        break;
      end

      // Slave drive for this cycle.
      arready = (cyc == 1 + ar_delay);
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
      rdata   = $urandom;
      if (in_recv) begin
        if (gap_mode == 0)      give = 1'b1;
        else if (gap_mode == 1) give = ((cyc - recv_start) % 2 == 0);
        else                    give = ($urandom_range(0, 1) == 1);
        if (give) begin
          rvalid = 1'b1;
          rdata  = words[sent];
          rresp  = (sent == err_beat) ? 2'b10 : 2'b00;
          rlast  = (sent == rlast_beat);
          sent++;
          if (sent == n_beats) write_exp = cyc + 1;
        end
      end
      step();
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    chk({name, ":completed_in_budget"}, 512'(finished), 512'(1'b1));
  endtask

  initial begin
    reset     = 1'b1;
    miss_req  = 1'b0;
    miss_addr = '0;
    flush_req = 1'b0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = '0;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst:miss_ready",  512'(miss_ready),  512'(1'b1));
    chk("rst:arvalid",     512'(arvalid),     512'(1'b0));
    chk("rst:rready",      512'(rready),      512'(1'b0));
    chk("rst:ram_wen",     512'(ram_wen),     512'(1'b0));
    chk("rst:ram_w_valid", 512'(ram_w_valid), 512'(1'b0));
    chk("rst:refill_done", 512'(refill_done), 512'(1'b0));
    chk("rst:refill_err",  512'(refill_err),  512'(1'b0));
    chk("rst:flush_done",  512'(flush_done),  512'(1'b0));
    chk("rst:araddr",      512'(araddr),      512'(0));
    chk("rst:ram_a",       512'(ram_a),       512'(0));
    chk("rst:ram_d",       512'(ram_d),       512'(0));
    chk("rst:ram_dina",    ram_dina,          512'(0));
    chk("rst:arlen",       512'(arlen),       512'(8'd15));
    chk("rst:arsize",      512'(arsize),      512'(3'd2));
    chk("rst:arburst",     512'(arburst),     512'(2'd1));
    reset = 1'b0;
    step();

    // Directed scenarios
    run_miss(32'h1FC0_1234, 0, 0, -1, 15, 1'b0, "clean");
    run_miss(32'h1FC0_1234, 3, 1, -1, 15, 1'b0, "backpressure");
    run_miss(32'h8765_4321, 0, 0,  7, 15, 1'b1, "rresp_err");
    run_miss(32'h0ABC_DEF0, 1, 0, -1,  9, 1'b1, "early_rlast");

    // Flush with a simultaneous miss: flush wins, miss is served afterwards.
    flush_req = 1'b1;
    miss_req  = 1'b1;
    miss_addr = 32'h2468_ACE0;
    step();
    flush_req = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      chk("flush:ram_wen",     512'(ram_wen),     512'(1'b1));
      chk("flush:ram_a",       512'(ram_a),       512'(cyc - 1));
      chk("flush:ram_w_valid", 512'(ram_w_valid), 512'(1'b0));
      chk("flush:ram_d",       512'(ram_d),       512'(0));
      chk("flush:ram_dina",    ram_dina,          512'(0));
      chk("flush:flush_done",  512'(flush_done),  512'(cyc == 64));
      chk("flush:miss_ready",  512'(miss_ready),  512'(1'b0));
      chk("flush:arvalid",     512'(arvalid),     512'(1'b0));
      step();
    end
    chk("flush:after_wen",        512'(ram_wen),    512'(1'b0));
    chk("flush:after_flush_done", 512'(flush_done), 512'(1'b0));
    run_miss(32'h2468_ACE0, 0, 0, -1, 15, 1'b1, "after_flush");

    // Reset while receiving beat 5.
    miss_req  = 1'b1;
    miss_addr = 32'h0040_0A80;
    step();
    miss_req  = 1'b0;
    arready   = 1'b1;
    step();
    arready   = 1'b0;
    for (int b = 0; b < 6; b++) begin
      rvalid = 1'b1;
      rdata  = 32'(b);
      rresp  = 2'b00;
      rlast  = 1'b0;
      if (b == 5) reset = 1'b1;
      chk("rstmid:ram_wen_before", 512'(ram_wen), 512'(1'b0));
      step();
    end
    reset  = 1'b0;
    rvalid = 1'b0;
    chk("rstmid:miss_ready",  512'(miss_ready),  512'(1'b1));
    chk("rstmid:rready",      512'(rready),      512'(1'b0));
    chk("rstmid:arvalid",     512'(arvalid),     512'(1'b0));
    chk("rstmid:refill_done", 512'(refill_done), 512'(1'b0));
    for (int i = 0; i < 4; i++) begin
      chk("rstmid:ram_wen_after", 512'(ram_wen), 512'(1'b0));
      step();
    end
    run_miss(32'h0040_0A80, 0, 0, -1, 15, 1'b1, "after_reset");

    // Randomized transactions against the reference model.
    for (int it = 0; it < 8; it++) begin
      int eb;
      int lb;
      eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : 15;
      run_miss($urandom, int'($urandom_range(0, 4)), 2, eb, lb, 1'b1, "random");
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss handler and line-refill engine for the instruction cache. It accepts a line-miss request from the ICache lookup stage and fetches the 64-byte line over a 16-beat AXI4 INCR read burst. It assembles the beats into a 512-bit line and writes tag, data and valid into the ICache tag/data/valid RAM port in a single cycle. It also provides a whole-cache invalidate sweep.

## Interface
- INDEX_SIZE, 6, line-index width (64 lines)
- WORD_OFF_SIZE, 4, word-offset width (16 x 32-bit words per line)
- TAG_SIZE, 20, tag width; TAG_SIZE+INDEX_SIZE+WORD_OFF_SIZE+2 = 32
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- miss_req  in  1  lookup stage requests refill of line containing miss_addr
- miss_addr  in  32  missing fetch address
- miss_ready  out  1  high only in IDLE; request accepted on miss_req & miss_ready
- refill_done  out  1  one-cycle pulse after the RAM write
- refill_err  out  1  valid with refill_done; 1 if any beat had rresp != 0
- flush_req  in  1  invalidate all lines
- flush_done  out  1  one-cycle pulse after the last line is cleared
- araddr  out  32; arlen  out  8; arsize  out  3; arburst  out  2; arvalid  out  1; arready  in  1
- rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1
- ram_wen  out  1  RAM write enable
- ram_a  out  INDEX_SIZE  RAM write line index
- ram_d  out  TAG_SIZE  tag written
- ram_dina  out  512  line data written
- ram_w_valid  out  1  valid bit written

## Operation
- States: IDLE, AR, RECV, WRITE, DONE, FLUSH.
- IDLE:
  - flush_req has priority over miss_req when both are high → FLUSH, index counter = 0.
  - Otherwise miss_req → AR. Latch tag = miss_addr[31:12] and index = miss_addr[11:6]. Clear beat counter and error flag.
- AR:
  - arvalid = 1.
  - araddr = {tag, index, 6'b0} (line-aligned, not critical-word-first).
  - arlen = 15, arsize = 3'b010, arburst = 2'b01.
  - All AR signals are held stable until arready, then → RECV.
- RECV:
  - rready = 1.
  - Each rvalid beat k (0..15) is stored in line bits [32k+31:32k], then the 4-bit beat counter increments.
  - rresp != 0 on any beat sets the error flag (sticky).
  - The beat with counter == 15 → WRITE, regardless of rlast.
  - rlast on a beat with counter != 15 also sets the error flag and → WRITE; words not received are 0.
  - Beats arriving outside RECV are not accepted (rready = 0).
- WRITE (exactly one cycle):
  - ram_wen = 1, ram_a = index, ram_d = tag, ram_dina = line.
  - ram_w_valid = !error.
  - → DONE.
- DONE: refill_done = 1 and refill_err = error for one cycle → IDLE.
- FLUSH:
  - Each cycle: ram_wen = 1, ram_a = counter, ram_w_valid = 0, ram_d = 0, ram_dina = 0.
  - At counter = 63: flush_done = 1 in that same cycle → IDLE.
  - The counter wraps to 0.
- miss_req or flush_req arriving while not in IDLE are ignored (miss_ready = 0); requesters hold them.
- Outside WRITE and FLUSH: ram_wen = 0.

## Timing
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Reset values:
  - State = IDLE; miss_ready = 1.
  - arvalid = rready = ram_wen = ram_w_valid = refill_done = refill_err = flush_done = 0.
  - araddr, ram_a, ram_d, ram_dina, line buffer = 0.
  - arlen = 15, arsize = 2, arburst = 1.
- Reset asserted mid-refill or mid-flush: on the next edge, state is IDLE and all handshake outputs are 0. No partial RAM write occurs. The AXI slave is reset by the same system reset.
- Miss path latency, zero wait states:
  - Accept at edge 0; arvalid high in cycle 1.
  - arready in cycle 1 → RECV in cycle 2.
  - Beats in cycles 2..17; WRITE in cycle 18; refill_done in cycle 19; miss_ready high in cycle 20.
- Each arready stall cycle adds 1 cycle. Each rvalid-low cycle adds 1 cycle.
- Flush: 64 write cycles, then IDLE on the following cycle.
- A RAM read in the cycle after WRITE observes the new line (RAM write-first timing is the RAM's responsibility).

## Test plan
- Clean miss: miss_addr = 0x1FC0_1234, zero-wait slave, rdata = beat index k. Required:
  - araddr = 0x1FC0_1200, arlen = 15.
  - One ram_wen pulse with ram_a = 8, ram_d = 0x1FC01, ram_dina word k = k, ram_w_valid = 1.
  - refill_done in cycle 19, refill_err = 0.
- Backpressure: arready delayed 3 cycles, rvalid low every other beat. Required:
  - AR signals stable throughout the stall.
  - Line identical to the clean miss; refill_done in cycle 19 + 3 + 15.
- Error: rresp = 2'b10 on beat 7. Required: ram_w_valid = 0, refill_err = 1, all 16 beats consumed.
- Early rlast on beat 9. Required: WRITE follows immediately, words 10..15 = 0, ram_w_valid = 0, refill_err = 1.
- Flush: flush_req and miss_req both high in IDLE. Required:
  - 64 consecutive ram_wen cycles, ram_a = 0..63, ram_w_valid = 0.
  - flush_done with ram_a = 63.
  - The miss is accepted afterwards.
- Reset during RECV at beat 5. Required:
  - Next cycle: IDLE, rready = 0, miss_ready = 1.
  - No ram_wen in the reset cycle or afterwards.
  - A following miss completes normally.
